// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and frame
// framing constants.
package imem_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam int LEN_BYTES = 2;
  localparam int CHK_BYTES = 1;
endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port. The loader sits on the
// master side; the host/memory pair sits on the slave side.
interface imem_loader_if #(parameter int ADDR_WIDTH = 5);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH+1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (input in_data, in_valid,
                  output in_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (output in_data, in_valid,
                  input in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader_word_packer.sv
// Assembles little-endian bytes into 32-bit words; word_ready pulses the cycle
// after the fourth lane is filled, with the complete word on word.
module word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        last_lane,
  output logic        word_ready,
  output logic [31:0] word
);
  logic [1:0] lane;

  assign last_lane = (lane == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane       <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= byte_en && last_lane;
      if (clr) begin
        lane <= '0;
      end else if (byte_en) begin
        word[{lane, 3'b000} +: 8] <= byte_in;
        lane                      <= lane + 2'd1;
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Framed host-stream loader: checks length, packs words, writes instruction
// memory and holds the CPU in reset until a checksum-valid frame has landed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);
  localparam int MAX_WORDS = 2 ** ADDR_WIDTH;

  state_t      state, state_nx;
  logic [7:0]  len_lo, chk;
  logic [15:0] len;
  logic        xfer, launch, byte_en, word_fire, last_word, last_lane;
  logic [15:0] len_in;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign launch    = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign byte_en   = xfer && (state == S_DATA);
  assign word_fire = byte_en && last_lane;
  assign last_word = word_fire && ((16'(words_loaded) + 16'd1) == len);
  assign len_in    = {bus.in_data, len_lo};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.in_ready = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nx = S_LEN_LO;
      S_LEN_LO: begin
        bus.in_ready = 1'b1;
        if (xfer) state_nx = S_LEN_HI;
      end
      S_LEN_HI: begin
        bus.in_ready = 1'b1;
        if (xfer) begin
          if (len_in > 16'(MAX_WORDS)) state_nx = S_ERROR;
          else if (len_in == 16'd0)    state_nx = S_CHECK;
          else                         state_nx = S_DATA;
        end
      end
      S_DATA: begin
        bus.in_ready = 1'b1;
        if (last_word) state_nx = S_CHECK;
      end
      S_CHECK: begin
        bus.in_ready = 1'b1;
        if (xfer) state_nx = (bus.in_data == chk) ? S_DONE : S_ERROR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign cpu_hold = (state != S_DONE);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);

  // Address and count move on the same edge that raises imem_we, so the
  // write cycle shows the pre-increment index on imem_addr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo        <= '0;
      len           <= '0;
      chk           <= '0;
      words_loaded  <= '0;
      bus.imem_addr <= '0;
    end else if (launch) begin
      chk          <= '0;
      words_loaded <= '0;
    end else begin
      if (xfer && (state == S_LEN_LO || state == S_LEN_HI || state == S_DATA))
        chk <= chk ^ bus.in_data;
      if (xfer && state == S_LEN_LO) len_lo <= bus.in_data;
      if (xfer && state == S_LEN_HI) len    <= len_in;
      if (word_fire) begin
        bus.imem_addr <= {words_loaded[ADDR_WIDTH-1:0], 2'b00};
        words_loaded  <= words_loaded + 1'b1;
      end
    end
  end

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (launch),
    .byte_en    (byte_en),
    .byte_in    (bus.in_data),
    .last_lane  (last_lane),
    .word_ready (bus.imem_we),
    .word       (bus.imem_wdata)
  );
endmodule
